// File: rtl/posit_norm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : posit_norm_ctrl_if
//  Purpose  : Valid/ready request and result bundle of the POSIT
//             normalization controller.
//  Revision : 1.0  initial release
// ============================================================================
interface posit_norm_ctrl_if #(
  parameter int BITS = 32,
  parameter int SW   = $clog2(BITS)
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic [SW-1:0]   out_shift;
  logic            out_zero;

  // Producer/consumer side, i.e. the neighbouring pipeline stages
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_zero
  );

  // Normalization controller side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/posit_norm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : posit_norm_ctrl
//  Purpose  : Multi-cycle leading-zero normalizer. Shifts the accepted word
//             left by at most MAX_STEP bits per cycle through a one-hot-mask
//             shifter until its MSB is set, then offers the normalized word,
//             total shift and zero flag on a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module posit_norm_ctrl #(
  parameter int BITS     = 32,
  parameter int MAX_STEP = 8,
  parameter int SW       = $clog2(BITS)
) (
  input  wire               clk,
  input  wire               rst_n,
  posit_norm_ctrl_if.slave  bus
);

  // Leading-zero count must be able to represent BITS (all-zero word)
  localparam int LZW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [BITS-1:0] work_q;
  logic [SW-1:0]   acc_q;
  logic            zflag_q;
  logic            out_valid_q;

  logic [LZW-1:0]  w_lz;
  logic [LZW-1:0]  w_step;
  logic            w_shift_en;
  logic [BITS-1:0] w_mask;
  logic [BITS-1:0] w_shifted;

  // Leading-zero count of the working word; the highest set bit wins
  always_comb begin
    w_lz = LZW'(BITS);
    for (int i = 0; i < BITS; i++) begin
      if (work_q[i]) begin
        w_lz = LZW'(BITS - 1 - i);
      end
    end
  end

  // Step size clipped to MAX_STEP; a step is only taken on a nonzero,
  // not-yet-normalized word so the mask is never all-zero while shifting
  always_comb begin
    w_step     = (w_lz > LZW'(MAX_STEP)) ? LZW'(MAX_STEP) : w_lz;
    w_shift_en = (state_q == ST_SHIFT) && (work_q != '0) && (w_lz != '0);
    w_mask     = '0;
    for (int p = 1; p < BITS; p++) begin
      if (w_shift_en && (int'(w_step) == BITS - p)) begin
        w_mask[p] = 1'b1;
      end
    end
  end

  // One-hot-mask shifter: mask bit p selects a left shift by BITS-p
  always_comb begin
    w_shifted = '0;
    for (int p = 1; p < BITS; p++) begin
      if (w_mask[p]) begin
        w_shifted = w_shifted | (work_q << (BITS - p));
      end
    end
  end

  // Control FSM with registered result and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      acc_q       <= '0;
      zflag_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            work_q  <= bus.in_data;
            acc_q   <= '0;
            zflag_q <= 1'b0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (work_q == '0) begin
            zflag_q     <= 1'b1;
            acc_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (w_lz == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            work_q <= w_shifted;
            acc_q  <= acc_q + SW'(w_step);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              // Back-to-back: next job loads on the same edge the result leaves
              work_q  <= bus.in_data;
              acc_q   <= '0;
              zflag_q <= 1'b0;
              state_q <= ST_SHIFT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // out_ready reaches in_ready combinationally so a finished job never stalls
  assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = work_q;
  assign bus.out_shift = acc_q;
  assign bus.out_zero  = zflag_q;

endmodule
`default_nettype wire

// File: tb/tb_posit_norm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_posit_norm_ctrl
//  Purpose  : Directed self-checking bench for posit_norm_ctrl, with one
//             instance at MAX_STEP=8 and one at MAX_STEP=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_posit_norm_ctrl;

  localparam int BITS = 32;
  localparam int SW   = $clog2(BITS);
  localparam int TMO  = 200;

  logic clk;
  logic rst_n;

  // Shared stimulus, steered to one instance by r_sel (0: step 8, 1: step 1)
  logic            r_sel;
  logic            r_valid;
  logic [BITS-1:0] r_data;
  logic            r_ready;

  int n_cmp;
  int n_err;

  posit_norm_ctrl_if #(.BITS(BITS), .SW(SW)) if_a ();
  posit_norm_ctrl_if #(.BITS(BITS), .SW(SW)) if_b ();

  posit_norm_ctrl #(.BITS(BITS), .MAX_STEP(8), .SW(SW)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  posit_norm_ctrl #(.BITS(BITS), .MAX_STEP(1), .SW(SW)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  assign if_a.in_valid  = r_valid & ~r_sel;
  assign if_b.in_valid  = r_valid &  r_sel;
  assign if_a.in_data   = r_data;
  assign if_b.in_data   = r_data;
  assign if_a.out_ready = r_ready & ~r_sel;
  assign if_b.out_ready = r_ready &  r_sel;

  wire            w_ovalid = r_sel ? if_b.out_valid : if_a.out_valid;
  wire            w_iready = r_sel ? if_b.in_ready  : if_a.in_ready;
  wire [BITS-1:0] w_odata  = r_sel ? if_b.out_data  : if_a.out_data;
  wire [SW-1:0]   w_oshift = r_sel ? if_b.out_shift : if_a.out_shift;
  wire            w_ozero  = r_sel ? if_b.out_zero  : if_a.out_zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a word, let it be accepted, wait for the result, check it and
  // consume it. Called #1 after a rising edge with the selected DUT idle.
  task automatic run_job(input string tag, input logic [BITS-1:0] din,
                         input logic [BITS-1:0] exp_data, input int exp_shift,
                         input logic exp_zero, input int exp_lat);
    int n;
    r_valid = 1'b1;
    r_data  = din;
    #1;
    check_val({tag, ".in_ready"}, 64'(w_iready), 64'd1);
    @(posedge clk);
    #1;
    r_valid = 1'b0;
    r_data  = 32'hDEAD_BEEF;   // must not affect the result
    n = 0;
    while (!w_ovalid && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({tag, ".latency"}, 64'(n), 64'(exp_lat));
    check_val({tag, ".data"},    64'(w_odata),  64'(exp_data));
    check_val({tag, ".shift"},   64'(w_oshift), 64'(exp_shift));
    check_val({tag, ".zero"},    64'(w_ozero),  64'(exp_zero));
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
    check_val({tag, ".consumed"}, 64'(w_ovalid), 64'd0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    r_sel   = 1'b0;
    r_valid = 1'b0;
    r_data  = '0;
    r_ready = 1'b0;
    rst_n   = 1'b0;
    #3;
    check_val("rst.in_ready",  64'(w_iready), 64'd1);
    check_val("rst.out_valid", 64'(w_ovalid), 64'd0);
    check_val("rst.out_data",  64'(w_odata),  64'd0);
    check_val("rst.out_shift", 64'(w_oshift), 64'd0);
    check_val("rst.out_zero",  64'(w_ozero),  64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_job("msb",    32'h8000_0000, 32'h8000_0000, 0,  1'b0, 1);
    run_job("x1234",  32'h0000_1234, 32'h91A0_0000, 19, 1'b0, 4);
    run_job("one",    32'h0000_0001, 32'h8000_0000, 31, 1'b0, 5);
    run_job("three",  32'h0000_0003, 32'hC000_0000, 30, 1'b0, 5);
    run_job("x8000",  32'h0000_8000, 32'h8000_0000, 16, 1'b0, 3);
    run_job("zero",   32'h0000_0000, 32'h0000_0000, 0,  1'b1, 1);

    // Single-bit-per-cycle instance
    r_sel = 1'b1;
    #1;
    run_job("s1.one", 32'h0000_0001, 32'h8000_0000, 31, 1'b0, 32);
    run_job("s1.x60", 32'h6000_0000, 32'hC000_0000, 1,  1'b0, 2);
    r_sel = 1'b0;
    #1;

    // Backpressure followed by a same-edge result/input handshake
    begin : bp
      int n;
      r_valid = 1'b1;
      r_data  = 32'h00F0_0000;
      @(posedge clk);
      #1;
      r_valid = 1'b0;
      n = 0;
      while (!w_ovalid && n < TMO) begin
        @(posedge clk);
        #1;
        n++;
      end
      check_val("bp.latency", 64'(n), 64'd2);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        check_val("bp.hold_valid", 64'(w_ovalid), 64'd1);
        check_val("bp.hold_data",  64'(w_odata),  64'h0000_0000_F000_0000);
        check_val("bp.hold_shift", 64'(w_oshift), 64'd8);
        check_val("bp.hold_zero",  64'(w_ozero),  64'd0);
        check_val("bp.in_ready",   64'(w_iready), 64'd0);
      end
      r_ready = 1'b1;
      r_valid = 1'b1;
      r_data  = 32'h4000_0000;
      #1;
      check_val("bp.ready_pass", 64'(w_iready), 64'd1);
      @(posedge clk);
      #1;
      r_ready = 1'b0;
      r_valid = 1'b0;
      r_data  = '0;
      check_val("bp.e0_valid", 64'(w_ovalid), 64'd0);
      @(posedge clk);
      #1;
      check_val("bp.e1_valid", 64'(w_ovalid), 64'd0);
      @(posedge clk);
      #1;
      check_val("bp.e2_valid", 64'(w_ovalid), 64'd1);
      check_val("bp.e2_data",  64'(w_odata),  64'h0000_0000_8000_0000);
      check_val("bp.e2_shift", 64'(w_oshift), 64'd1);
      r_ready = 1'b1;
      @(posedge clk);
      #1;
      r_ready = 1'b0;
    end

    // Asynchronous reset in the middle of a shift sequence
    r_valid = 1'b1;
    r_data  = 32'h0000_0001;
    @(posedge clk);
    #1;
    r_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid.partial", 64'(w_odata), 64'h0000_0000_0000_0100);
    rst_n = 1'b0;
    #1;
    check_val("mid.out_valid", 64'(w_ovalid), 64'd0);
    check_val("mid.in_ready",  64'(w_iready), 64'd1);
    check_val("mid.out_data",  64'(w_odata),  64'd0);
    check_val("mid.out_shift", 64'(w_oshift), 64'd0);
    check_val("mid.out_zero",  64'(w_ozero),  64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check_val("mid.no_stale", 64'(w_ovalid), 64'd0);
    end
    run_job("post", 32'h2000_0000, 32'h8000_0000, 2, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
